// File: rtl/serial_word_pkg.sv
// Shared constants and FSM state type for the serial word receiver.
package serial_word_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned CNT_W  = 4;

    // Index of the final bit of a word; its transfer completes the word.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } state_t;

endpackage

// File: rtl/word_out_reg.sv
// Output holding register: loads a completed word, clears valid when consumed.
module word_out_reg #(
    parameter int unsigned WORD_W = serial_word_pkg::WORD_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              word_ready,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid
);

    // A load wins over a consume in the same cycle, so a replacement word keeps valid high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word_out   <= '0;
            word_valid <= 1'b0;
        end else if (load) begin
            word_out   <= load_data;
            word_valid <= 1'b1;
        end else if (word_ready) begin
            word_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_word_rx.sv
// Serial-to-parallel receiver: collects LSB-first bits into words, stalls
// when the output register is full, and hands words downstream via valid/ready.
module serial_word_rx #(
    parameter int unsigned WORD_W = serial_word_pkg::WORD_W
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              sync_clear,
    input  logic                              bit_in,
    input  logic                              bit_valid,
    output logic                              bit_ready,
    output logic [WORD_W-1:0]                 word_out,
    output logic                              word_valid,
    input  logic                              word_ready,
    output logic [serial_word_pkg::CNT_W-1:0] bit_count
);
    import serial_word_pkg::*;

    state_t            state, state_next;
    logic [WORD_W-1:0] shreg, shreg_next, assembled, load_data;
    logic [CNT_W-1:0]  count_next;
    logic              bit_xfer, word_xfer, load;

    // bit_ready depends on state alone, never on bit_valid.
    assign bit_ready = (state == COLLECT);
    assign bit_xfer  = bit_valid && bit_ready && !sync_clear;
    assign word_xfer = word_valid && word_ready;

    // Next-state, shift register and output-load decode.
    always_comb begin
        state_next = state;
        shreg_next = shreg;
        count_next = bit_count;
        load       = 1'b0;
        load_data  = shreg;
        assembled  = shreg;
        assembled[bit_count] = bit_in;

        if (sync_clear) begin
            state_next = COLLECT;
            shreg_next = '0;
            count_next = '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (bit_xfer) begin
                        if (bit_count == LAST_BIT) begin
                            count_next = '0;
                            if (!word_valid || word_xfer) begin
                                load       = 1'b1;
                                load_data  = assembled;
                                shreg_next = '0;
                            end else begin
                                state_next = STALL;
                                shreg_next = assembled;
                            end
                        end else begin
                            shreg_next = assembled;
                            count_next = bit_count + CNT_W'(1);
                        end
                    end
                end
                STALL: begin
                    if (word_xfer) begin
                        load       = 1'b1;
                        load_data  = shreg;
                        shreg_next = '0;
                        state_next = COLLECT;
                    end
                end
                default: state_next = COLLECT;
            endcase
        end
    end

    // State, shift register and bit counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= COLLECT;
            shreg     <= '0;
            bit_count <= '0;
        end else begin
            state     <= state_next;
            shreg     <= shreg_next;
            bit_count <= count_next;
        end
    end

    word_out_reg #(
        .WORD_W(WORD_W)
    ) u_word_out_reg (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .load_data  (load_data),
        .word_ready (word_ready),
        .word_out   (word_out),
        .word_valid (word_valid)
    );

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed self-checking bench for serial_word_rx.
module tb_serial_word_rx;

    logic        clock;
    logic        reset;
    logic        sync_clear;
    logic        bit_in;
    logic        bit_valid;
    logic        bit_ready;
    logic [15:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic [3:0]  bit_count;

    int checks = 0;
    int passed = 0;

    serial_word_rx #(.WORD_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .sync_clear (sync_clear),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .bit_count  (bit_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 0; i < 16; i++) begin
            bit_in    = w[i];
            bit_valid = 1'b1;
            step();
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic drain();
        word_ready = 1'b1;
        step();
        word_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; sync_clear = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; word_ready = 1'b0;
        #1 reset = 1'b1;
        #1;
        checks++; if (word_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", word_valid); else passed++;
        checks++; if (word_out !== 16'h0000) $display("FAIL reset_word got %h want 0000", word_out); else passed++;
        checks++; if (bit_count !== 4'd0) $display("FAIL reset_count got %0d want 0", bit_count); else passed++;
        step(); step();
        reset = 1'b0;
        step();
        checks++; if (bit_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bit_ready); else passed++;
    endtask

    task automatic test_basic();
        logic [15:0] w;
        w = 16'hA5C3;
        word_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            bit_in = w[i]; bit_valid = 1'b1; step();
        end
        checks++; if (word_valid !== 1'b0) $display("FAIL basic_early_valid got %b want 0", word_valid); else passed++;
        checks++; if (bit_count !== 4'd15) $display("FAIL basic_count15 got %0d want 15", bit_count); else passed++;
        bit_in = w[15]; step();
        bit_valid = 1'b0;
        checks++; if (word_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", word_valid); else passed++;
        checks++; if (word_out !== 16'hA5C3) $display("FAIL basic_word got %h want a5c3", word_out); else passed++;
        checks++; if (bit_count !== 4'd0) $display("FAIL basic_wrap got %0d want 0", bit_count); else passed++;
        step();
        checks++; if (word_valid !== 1'b0) $display("FAIL basic_consume got %b want 0", word_valid); else passed++;
        word_ready = 1'b0;
    endtask

    task automatic test_gapped();
        logic [15:0] w;
        int bad;
        w = 16'h8001;
        bad = 0;
        word_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bit_in = w[i]; bit_valid = 1'b1; step();
            if (i == 15) begin
                checks++; if (word_out !== 16'h8001 || word_valid !== 1'b1)
                    $display("FAIL gapped_word got %h/%b want 8001/1", word_out, word_valid); else passed++;
            end
            bit_valid = 1'b0; bit_in = ~w[i]; step();
            if (bit_count !== 4'((i + 1) % 16)) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL gapped_count got %0d bad cycles want 0", bad); else passed++;
        word_ready = 1'b0;
    endtask

    task automatic test_sync_clear();
        word_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bit_in = 1'b1; bit_valid = 1'b1; step();
        end
        checks++; if (bit_count !== 4'd7) $display("FAIL sclr_pre_count got %0d want 7", bit_count); else passed++;
        sync_clear = 1'b1; bit_in = 1'b1; bit_valid = 1'b1;
        step();
        sync_clear = 1'b0; bit_valid = 1'b0;
        checks++; if (bit_count !== 4'd0) $display("FAIL sclr_count got %0d want 0", bit_count); else passed++;
        checks++; if (word_valid !== 1'b0) $display("FAIL sclr_valid got %b want 0", word_valid); else passed++;
        send_word(16'h00FF);
        checks++; if (word_out !== 16'h00FF || word_valid !== 1'b1)
            $display("FAIL sclr_word got %h/%b want 00ff/1", word_out, word_valid); else passed++;
        drain();
    endtask

    task automatic test_sync_clear_stall();
        word_ready = 1'b0;
        send_word(16'h1111);
        send_word(16'h2222);
        checks++; if (bit_ready !== 1'b0) $display("FAIL sclr_stall_pre got %b want 0", bit_ready); else passed++;
        sync_clear = 1'b1; step(); sync_clear = 1'b0;
        checks++; if (bit_ready !== 1'b1) $display("FAIL sclr_stall_ready got %b want 1", bit_ready); else passed++;
        checks++; if (word_out !== 16'h1111 || word_valid !== 1'b1)
            $display("FAIL sclr_stall_out got %h/%b want 1111/1", word_out, word_valid); else passed++;
        word_ready = 1'b1; step(); word_ready = 1'b0;
        checks++; if (word_valid !== 1'b0 || word_out !== 16'h1111)
            $display("FAIL sclr_stall_discard got %h/%b want 1111/0", word_out, word_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] stream;
        int ready_low, valid_cycles;
        stream = {16'hF0F0, 16'h0F0F};
        ready_low = 0; valid_cycles = 0;
        word_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (bit_ready !== 1'b1) ready_low++;
            bit_in = stream[i]; bit_valid = 1'b1; step();
            if (word_valid === 1'b1) valid_cycles++;
            if (i == 15) begin
                checks++; if (word_out !== 16'h0F0F || word_valid !== 1'b1)
                    $display("FAIL b2b_first got %h/%b want 0f0f/1", word_out, word_valid); else passed++;
            end
            if (i == 31) begin
                checks++; if (word_out !== 16'hF0F0 || word_valid !== 1'b1)
                    $display("FAIL b2b_second got %h/%b want f0f0/1", word_out, word_valid); else passed++;
            end
        end
        bit_valid = 1'b0;
        checks++; if (ready_low !== 0) $display("FAIL b2b_ready got %0d low cycles want 0", ready_low); else passed++;
        checks++; if (valid_cycles !== 2) $display("FAIL b2b_valid_cycles got %0d want 2", valid_cycles); else passed++;
        drain();
    endtask

    task automatic test_backpressure();
        word_ready = 1'b0;
        send_word(16'h1234);
        checks++; if (word_out !== 16'h1234 || word_valid !== 1'b1)
            $display("FAIL bp_first got %h/%b want 1234/1", word_out, word_valid); else passed++;
        send_word(16'hFFFF);
        checks++; if (bit_ready !== 1'b0) $display("FAIL bp_stall_ready got %b want 0", bit_ready); else passed++;
        checks++; if (bit_count !== 4'd0) $display("FAIL bp_stall_count got %0d want 0", bit_count); else passed++;
        bit_in = 1'b1; bit_valid = 1'b1;
        step(); step(); step();
        bit_valid = 1'b0;
        checks++; if (word_out !== 16'h1234 || word_valid !== 1'b1 || bit_ready !== 1'b0)
            $display("FAIL bp_hold got %h/%b/%b want 1234/1/0", word_out, word_valid, bit_ready); else passed++;
        word_ready = 1'b1; step(); word_ready = 1'b0;
        checks++; if (word_out !== 16'hFFFF || word_valid !== 1'b1)
            $display("FAIL bp_release got %h/%b want ffff/1", word_out, word_valid); else passed++;
        checks++; if (bit_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", bit_ready); else passed++;
    endtask

    task automatic test_reset_stall();
        int emitted;
        emitted = 0;
        word_ready = 1'b0;
        send_word(16'h5A5A);
        checks++; if (bit_ready !== 1'b0) $display("FAIL rst_stall_pre got %b want 0", bit_ready); else passed++;
        #2 reset = 1'b1;
        #1;
        checks++; if (word_valid !== 1'b0 || bit_count !== 4'd0 || word_out !== 16'h0000)
            $display("FAIL rst_async got %b/%0d/%h want 0/0/0000", word_valid, bit_count, word_out); else passed++;
        #1 reset = 1'b0;
        word_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (word_valid !== 1'b0) emitted++;
        end
        word_ready = 1'b0;
        checks++; if (emitted !== 0) $display("FAIL rst_no_emit got %0d cycles want 0", emitted); else passed++;
        checks++; if (bit_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", bit_ready); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_sync_clear();
        test_sync_clear_stall();
        test_back_to_back();
        test_backpressure();
        test_reset_stall();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_word_rx.md
SERIAL_WORD_RX -- requirements
Module: serial_word_rx

Interface
REQ-001 Parameter: WORD_W, default 16, assembled word width in bits (fixed at 16 for this release).
REQ-002 Ports (name, direction, width, meaning):
- clock, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- sync_clear, in, 1: synchronous discard of the partial or stalled word.
- bit_in, in, 1: serial data bit, LSB first.
- bit_valid, in, 1: bit_in is valid this cycle.
- bit_ready, out, 1: the block accepts a bit this cycle.
- word_out, out, 16: assembled word.
- word_valid, out, 1: word_out holds an unconsumed word.
- word_ready, in, 1: downstream consumes word_out this cycle.
- bit_count, out, 4: number of bits collected into the current partial word.
REQ-003 One clock; reset is asynchronous and active-high.

Function
REQ-004 A bit transfer occurs when bit_valid=1, bit_ready=1 and sync_clear=0.
REQ-005 A word transfer occurs when word_valid=1 and word_ready=1.
REQ-006 On each bit transfer, bit_in is written to shreg[bit_count] (LSB first) and bit_count increments.
REQ-007 FSM state COLLECT: bit_ready=1. The transfer of the 16th bit (bit_count=15) completes the word.
REQ-008 On completion, if the output register is empty or a word transfer occurs in the same cycle:
- word_out loads the completed word at that edge;
- word_valid=1 on the next cycle (latency 1);
- bit_count wraps to 0;
- the FSM stays in COLLECT.
REQ-009 On completion with the output register full and no word transfer in that cycle: the FSM goes to STALL, the full word is held in shreg, and bit_count reads 0.
REQ-010 FSM state STALL: bit_ready=0. On a word transfer, word_out loads shreg, word_valid stays 1, and the FSM returns to COLLECT on the next cycle.
REQ-011 A word transfer with no replacement word pending clears word_valid at that edge.
REQ-012 word_out and word_valid are stable while word_valid=1 and word_ready=0.
REQ-013 sync_clear=1:
- bit_count goes to 0;
- shreg is cleared;
- STALL goes to COLLECT and the stalled word is discarded;
- the output register and word_valid are unaffected;
- sync_clear has priority over a bit transfer in the same cycle.
REQ-014 A bit transfer with bit_count<15 and a simultaneous word transfer are independent; neither blocks the other.
REQ-015 bit_ready is combinational from state only, never from bit_valid, so no combinational path runs from bit_valid to bit_ready.
REQ-016 word_ready may be asserted while word_valid=0; the block ignores it.

Reset
REQ-017 reset=1 asynchronously forces the following, overriding all other inputs:
- state=COLLECT;
- bit_count=0, shreg=0;
- word_out=16'h0000, word_valid=0;
- bit_ready=1 once reset deasserts.
REQ-018 Reset asserted mid-word or in STALL discards all held data; no word is emitted after reset.

Structure
REQ-019 A shared package serial_word_pkg holds WORD_W=16, CNT_W=4 and the state enum {COLLECT, STALL}.
REQ-020 The output holding register (word_out and word_valid with the valid/ready load/clear logic) is the single sub-module, word_out_reg.
REQ-021 shreg, bit_count and the FSM live in the top level.

Verification
REQ-022 Basic assembly: reset, then send the bits of 16'hA5C3 LSB first (1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1) with word_ready=1. Required: word_valid=1 and word_out=16'hA5C3 exactly one cycle after the 16th bit.
REQ-023 Backpressure: hold word_ready=0 and send 16'h1234 then 16'hFFFF. Required:
- bit_ready=0 after the 32nd bit;
- word_out stays 16'h1234;
- on a single-cycle word_ready pulse, word_out becomes 16'hFFFF and bit_ready=1 on the next cycle.
REQ-024 Gapped input: send 16'h8001 with bit_valid toggling every other cycle. Required: word_out=16'h8001 and bit_count advances only on transfers.
REQ-025 sync_clear: send 7 bits, then assert sync_clear together with bit_valid. Required:
- bit_count=0 on the next cycle;
- the following 16 bits of 16'h00FF yield word_out=16'h00FF.
REQ-026 Reset mid-operation: assert reset asynchronously during the STALL produced by REQ-023. Required: word_valid=0, bit_count=0 and word_out=16'h0000 immediately, with no word emitted afterwards.
REQ-027 Back-to-back throughput: send 16'h0F0F then 16'hF0F0 with word_ready=1 and no idle cycles. Required: both words are emitted 16 cycles apart and bit_ready is never deasserted.
